uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one UART transmit line among `N_REQ` byte producers (button handlers, status reporters, debug taps). It owns the baud timing and the 10-bit frame shifter: start bit, 8 data bits LSB-first, stop bit. A byte is accepted from exactly one requester per frame, and frames go out back-to-back with no idle gap. It replaces per-source transmitters that would otherwise fight over the single `txd` pin.

## Interface
- `CLKS_PER_BIT`, 10417, clock cycles per bit (100 MHz / 9600 baud); legal range 2..65535.
- `N_REQ`, 4, number of requesters; legal range 2..8.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  N_REQ  per-requester "byte pending"; held high until granted.
- `req_data`  in  8*N_REQ  byte of requester i on bits [8i+7:8i]; stable while `req[i]` is high.
- `grant`  out  N_REQ  one-hot, one-cycle pulse: byte of that requester captured this edge.
- `active_id`  out  $clog2(N_REQ)  index of requester whose frame is on the line.
- `busy`  out  1  high while a frame is being shifted.
- `txd`  out  1  serial output, idle high.

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE: `txd`=1, `busy`=0. On an edge with `|req`:
  - pick the winner by round-robin from pointer `rr_ptr`;
  - capture its byte; pulse `grant[winner]`; set `active_id`;
  - set `txd`<=0, `busy`<=1, clear the baud counter, and go to START.
- Round-robin: search order is `rr_ptr`, `rr_ptr+1`, … modulo N_REQ. After a grant, `rr_ptr` <= winner+1, modulo N_REQ.
- START: `txd`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: `txd`=data[bit index] for CLKS_PER_BIT cycles per bit, LSB first. After bit 7, go to STOP.
- STOP: `txd`=1 for CLKS_PER_BIT cycles. On the last cycle:
  - if `|req`, arbitrate and go directly to START (same actions as IDLE);
  - otherwise go to IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0; the bit/state advance happens on the wrap. It is reset to 0 only at frame start.
- Bit index: 3 bits, 0..7, no wrap beyond 7.
- `req[i]` dropped before grant: the request is withdrawn, with no side effects. `req_data` changes after grant are ignored.
- `req` rising mid-frame: that requester waits; it is never granted before the current frame's STOP completes.
- All requests simultaneous: exactly one grant per frame, in pointer order.

## Timing
- Reset values: `txd`=1, `busy`=0, `grant`=0, `active_id`=0, `rr_ptr`=0, state IDLE, counters 0.
- Latency: with `req` first sampled high at edge t in IDLE:
  - `grant` is high during cycle t+1 only;
  - `txd` goes low at edge t;
  - the start bit occupies cycles t+1 .. t+CLKS_PER_BIT.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- `busy` falls at the end of a frame only if no request is pending. It stays high across back-to-back frames.
- Reset mid-frame: at the reset edge, outputs return to reset values. The frame is abandoned (line returns high, no grant is issued), and `rr_ptr` returns to 0.

## Structure
- Shared package `uart_pkg`:
  - `CLKS_PER_BIT` default;
  - `UART_DATA_BITS`=8 and `UART_FRAME_BITS`=10;
  - state enum type `uart_tx_state_t`.
- Sub-module `uart_tx_core`:
  - inputs `load`, `din[7:0]`; outputs `txd`, `busy`, `last_cycle` (high on the final stop-bit cycle);
  - holds the baud counter, bit index and state.
- `uart_tx_arbiter` contains only the round-robin picker, grant/active_id registers, and the core instance. Arbitration fires when the core is idle or `last_cycle` is high.

## Test plan
Run with CLKS_PER_BIT=4 and N_REQ=4.
- Single request: `req`=4'b0001, byte 0x39 → `grant`=0001 for one cycle; `txd` = 0, then 1,0,0,1,1,1,0,0, then 1, each bit 4 cycles (40-cycle frame); `busy` then falls.
- All requesters held with bytes 0x10, 0x11, 0x12, 0x13 → grants in order 0, 1, 2, 3, then 0; frames contiguous with no idle cycle; `active_id` tracks the grants.
- Request from requester 2 only, then requesters 1 and 3 together → requester 3 is granted before requester 1.
- `req[1]` raised for 3 cycles during another requester's DATA phase, then dropped → requester 1 never receives a grant and the line goes idle after the current frame.
- `rst_n`=0 for one cycle during bit 4 of a frame → `txd`=1, `busy`=0, `grant`=0 on the next cycle; a subsequent request from requester 3 is granted normally with `rr_ptr` restarted at 0.
- `req` steady low for 100 cycles → `txd` stays 1 and `grant` never pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default baud divisor, frame geometry and the
// transmit state encoding used by the serial core.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 10417;
    localparam int UART_DATA_BITS    = 8;
    localparam int UART_FRAME_BITS   = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 transmit engine: baud counter, bit index and frame shifter. A load on
// the final stop-bit cycle chains the next frame with no idle gap.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] din,
    output logic       txd,
    output logic       busy,
    output logic       last_cycle
);

    localparam int             CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     BIT_LAST = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t state_r, state_n;
    logic [CW-1:0]  cnt_r, cnt_n;
    logic [2:0]     bit_r, bit_n;
    logic [7:0]     shreg_r, shreg_n;
    logic           txd_r, txd_n;
    logic           busy_r, busy_n;
    logic           wrap_s;

    assign wrap_s     = (cnt_r == CNT_MAX);
    assign last_cycle = (state_r == ST_STOP) && wrap_s;
    assign txd        = txd_r;
    assign busy       = busy_r;

    // Next-state and next-output decode for the frame sequencer
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        bit_n   = bit_r;
        shreg_n = shreg_r;
        txd_n   = txd_r;
        busy_n  = busy_r;
        case (state_r)
            ST_IDLE: begin
                if (load) begin
                    state_n = ST_START;
                    cnt_n   = '0;
                    bit_n   = 3'd0;
                    shreg_n = din;
                    txd_n   = 1'b0;
                    busy_n  = 1'b1;
                end else begin
                    txd_n  = 1'b1;
                    busy_n = 1'b0;
                end
            end
            ST_START: begin
                if (wrap_s) begin
                    state_n = ST_DATA;
                    cnt_n   = '0;
                    bit_n   = 3'd0;
                    txd_n   = shreg_r[0];
                end else begin
                    cnt_n = cnt_r + CW'(1);
                end
            end
            ST_DATA: begin
                if (wrap_s) begin
                    cnt_n = '0;
                    if (bit_r == BIT_LAST) begin
                        state_n = ST_STOP;
                        txd_n   = 1'b1;
                    end else begin
                        // shift so the next data bit always sits at [0]
                        bit_n   = bit_r + 3'd1;
                        shreg_n = {1'b0, shreg_r[7:1]};
                        txd_n   = shreg_r[1];
                    end
                end else begin
                    cnt_n = cnt_r + CW'(1);
                end
            end
            ST_STOP: begin
                if (wrap_s) begin
                    cnt_n = '0;
                    bit_n = 3'd0;
                    if (load) begin
                        state_n = ST_START;
                        shreg_n = din;
                        txd_n   = 1'b0;
                        busy_n  = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                        txd_n   = 1'b1;
                        busy_n  = 1'b0;
                    end
                end else begin
                    cnt_n = cnt_r + CW'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
                bit_n   = 3'd0;
                shreg_n = 8'h00;
                txd_n   = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    // Frame sequencer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            bit_r   <= 3'd0;
            shreg_r <= 8'h00;
            txd_r   <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            bit_r   <= bit_n;
            shreg_r <= shreg_n;
            txd_r   <= txd_n;
            busy_r  <= busy_n;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among N_REQ byte producers.
// Arbitration fires when the core is idle or on its final stop-bit cycle.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int N_REQ        = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [8*N_REQ-1:0]       req_data,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] active_id,
    output logic                     busy,
    output logic                     txd
);

    localparam int             IW      = $clog2(N_REQ);
    localparam logic [IW-1:0]  ID_LAST = IW'(N_REQ - 1);

    logic [N_REQ-1:0] grant_r, grant_n;
    logic [IW-1:0]    active_id_r, active_id_n;
    logic [IW-1:0]    rr_ptr_r, rr_ptr_n;
    logic [IW-1:0]    winner_s;
    logic [7:0]       din_s;
    logic             arb_en_s;
    logic             core_busy_s;
    logic             core_last_s;

    // First requester at or after ptr, wrapping modulo N_REQ
    function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [IW-1:0]    ptr);
        logic [2*N_REQ-1:0] dbl;
        logic [IW:0]        sum;
        logic [IW-1:0]      win;
        logic               found;
        dbl   = {r, r} >> ptr;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && dbl[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (IW+1)'(k);
                if (sum >= (IW+1)'(N_REQ)) begin
                    sum = sum - (IW+1)'(N_REQ);
                end else begin
                    sum = sum;
                end
                win = sum[IW-1:0];
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

    assign arb_en_s = (!core_busy_s || core_last_s) && (|req);
    assign winner_s = rr_pick(req, rr_ptr_r);
    assign din_s    = req_data[{winner_s, 3'b000} +: 8];

    // Grant, active index and pointer update on an arbitration edge
    always_comb begin
        grant_n     = '0;
        active_id_n = active_id_r;
        rr_ptr_n    = rr_ptr_r;
        if (arb_en_s) begin
            grant_n     = {{(N_REQ-1){1'b0}}, 1'b1} << winner_s;
            active_id_n = winner_s;
            rr_ptr_n    = (winner_s == ID_LAST) ? '0 : winner_s + IW'(1);
        end else begin
            grant_n = '0;
        end
    end

    // Arbiter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_r     <= '0;
            active_id_r <= '0;
            rr_ptr_r    <= '0;
        end else begin
            grant_r     <= grant_n;
            active_id_r <= active_id_n;
            rr_ptr_r    <= rr_ptr_n;
        end
    end

    assign grant     = grant_r;
    assign active_id = active_id_r;
    assign busy      = core_busy_s;

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (arb_en_s),
        .din        (din_s),
        .txd        (txd),
        .busy       (core_busy_s),
        .last_cycle (core_last_s)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter at CLKS_PER_BIT=4, N_REQ=4: a table of
// isolated frames plus hand sequences for back-to-back, withdraw and reset.
module tb_uart_tx_arbiter;

    localparam int CPB = 4;
    localparam int NR  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0] grant;
    logic [1:0]    active_id;
    logic          busy;
    logic          txd;

    int nvec  = 0;
    int nfail = 0;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  g;
        logic [1:0]  id;
        logic [7:0]  b;
    } vec_t;

    vec_t vt[6];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.CLKS_PER_BIT(CPB), .N_REQ(NR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .grant     (grant),
        .active_id (active_id),
        .busy      (busy),
        .txd       (txd)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Entered in the cycle right after the grant edge; walks all 40 cycles.
    task automatic check_frame(input logic [7:0] b, input logic [1:0] id, input logic [3:0] g,
                               input logic [3:0] clr, input logic [3:0] setm,
                               input int set_at, input int set_len);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int c = 0; c < 10*CPB; c++) begin
            chk("txd", {31'd0, txd}, {31'd0, fr[c/CPB]});
            chk("busy", {31'd0, busy}, 32'd1);
            chk("grant", {28'd0, grant}, (c == 0) ? {28'd0, g} : 32'd0);
            chk("active_id", {30'd0, active_id}, {30'd0, id});
            if (c == 0) req = req & ~clr;
            if (c == set_at) req = req | setm;
            if (set_len > 0 && c == set_at + set_len) req = req & ~setm;
            step();
        end
    endtask

    initial begin
        int bad;
        vt[0] = '{4'b0001, 32'h0000_0039, 4'b0001, 2'd0, 8'h39};
        vt[1] = '{4'b0001, 32'h0000_00A5, 4'b0001, 2'd0, 8'hA5};
        vt[2] = '{4'b1001, 32'h5A00_0000, 4'b1000, 2'd3, 8'h5A};
        vt[3] = '{4'b0110, 32'h007E_C300, 4'b0010, 2'd1, 8'hC3};
        vt[4] = '{4'b0011, 32'h0000_01FF, 4'b0001, 2'd0, 8'hFF};
        vt[5] = '{4'b0100, 32'h0080_0000, 4'b0100, 2'd2, 8'h80};

        rst_n    = 1'b0;
        req      = 4'b0000;
        req_data = 32'h0000_0000;
        step();
        step();
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_active_id", {30'd0, active_id}, 32'd0);
        rst_n = 1'b1;
        step();

        // isolated frames from idle, pointer carried between rows
        for (int i = 0; i < 6; i++) begin
            req_data = vt[i].data;
            req      = vt[i].req;
            step();
            check_frame(vt[i].b, vt[i].id, vt[i].g, 4'hF, 4'h0, -1, 0);
            chk("busy_falls", {31'd0, busy}, 32'd0);
            chk("idle_txd", {31'd0, txd}, 32'd1);
            step();
        end

        // requester 2 alone, then 1 and 3 together mid-frame: 3 before 1
        req_data = 32'h3322_1100;
        req      = 4'b0100;
        step();
        check_frame(8'h22, 2'd2, 4'b0100, 4'b0100, 4'b1010, 10, 0);
        check_frame(8'h33, 2'd3, 4'b1000, 4'b1000, 4'b0000, -1, 0);
        check_frame(8'h11, 2'd1, 4'b0010, 4'b0010, 4'b0000, -1, 0);
        chk("busy_after_rr", {31'd0, busy}, 32'd0);
        step();

        // req[1] pulsed for 3 cycles during DATA is never granted
        req_data = 32'h0000_0096;
        req      = 4'b0001;
        step();
        check_frame(8'h96, 2'd0, 4'b0001, 4'b0001, 4'b0010, 14, 3);
        chk("busy_after_withdraw", {31'd0, busy}, 32'd0);
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            if (grant !== 4'b0000 || txd !== 1'b1 || busy !== 1'b0) bad++;
            step();
        end
        chk("no_grant_after_withdraw", bad, 32'd0);

        // reset for one cycle during data bit 4
        req_data = 32'h0000_EF00;
        req      = 4'b0010;
        step();
        chk("pre_rst_grant", {28'd0, grant}, 32'h2);
        chk("pre_rst_id", {30'd0, active_id}, 32'd1);
        req = 4'b0000;
        for (int c = 0; c < 21; c++) step();
        chk("pre_rst_bit4", {31'd0, txd}, 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_txd", {31'd0, txd}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_grant", {28'd0, grant}, 32'd0);
        chk("mid_rst_id", {30'd0, active_id}, 32'd0);
        step();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // pointer restarted at 0: 1 wins over 3
        req_data = 32'hB400_4B00;
        req      = 4'b1010;
        step();
        check_frame(8'h4B, 2'd1, 4'b0010, 4'hF, 4'h0, -1, 0);
        chk("busy_after_ptr", {31'd0, busy}, 32'd0);
        req_data = 32'hD200_0000;
        req      = 4'b1000;
        step();
        check_frame(8'hD2, 2'd3, 4'b1000, 4'hF, 4'h0, -1, 0);
        chk("busy_after_r3", {31'd0, busy}, 32'd0);

        // all four held: grants 0,1,2,3,0 with contiguous frames
        req_data = 32'h1312_1110;
        req      = 4'b1111;
        step();
        for (int f = 0; f < 5; f++) begin
            check_frame(8'h10 + 8'(f % 4), 2'(f % 4), 4'(1 << (f % 4)),
                        (f == 4) ? 4'hF : 4'h0, 4'h0, -1, 0);
        end
        chk("busy_after_all", {31'd0, busy}, 32'd0);
        chk("txd_after_all", {31'd0, txd}, 32'd1);

        // 100 quiet cycles
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            if (txd !== 1'b1 || grant !== 4'b0000 || busy !== 1'b0) bad++;
            step();
        end
        chk("idle_quiet", bad, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
